// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between the RV32I MEM stage and a req/gnt/rvalid data-memory port.
// One access in flight; checks alignment/funct3, builds byte enables and lane data, extends loads.
module riscv_lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  rsp_err_o,
    output logic                  stall_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    function automatic logic op_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic aligned;
        if (we) begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end
        case (f3[1:0])
            2'b01:   aligned = ~a[0];
            2'b10:   aligned = (a == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h000000, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0000, s[15:0]};
            default: return rdata;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [4:0]              rd_q;
    logic                    err_q;
    logic                    accept_s;
    logic                    ok_s;
    logic                    to_s;

    assign accept_s = (state_q == S_IDLE) && req_valid_i;
    assign ok_s     = op_ok(req_we_i, req_funct3_i, req_addr_i[1:0]);
    // Counter value TIMEOUT-1 marks the last permitted cycle in REQ/WAIT_R.
    assign to_s     = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a grant or read-data beat wins over the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cnt_d   = '0;
                    state_d = ok_s ? S_REQ : S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_gnt_i) begin
                    state_d = we_q ? S_RESP : S_WAIT_R;
                end else if (to_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid_i || to_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT_R;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Captured request, prepared memory-side fields, and response data/error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
        end else if (accept_s) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[1:0];
            addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            be_q    <= calc_be(req_funct3_i, req_addr_i[1:0]);
            wdata_q <= calc_wdata(req_funct3_i, req_wdata_i);
            rd_q    <= req_rd_i;
            rdata_q <= '0;
            err_q   <= ~ok_s;
        end else if ((state_q == S_WAIT_R) && mem_rvalid_i) begin
            rdata_q <= extract(f3_q, off_q, mem_rdata_i);
        end else if ((((state_q == S_REQ) && !mem_gnt_i) || (state_q == S_WAIT_R)) && to_s) begin
            err_q   <= 1'b1;
        end else begin
            err_q   <= err_q;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_rd_o    = rd_q;
    assign rsp_err_o   = err_q;
    assign stall_o     = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_REQ) ||
                         (state_q == S_WAIT_R);

endmodule
